// File: rtl/myproject_mul_share_arb_if.sv
// Requester/result bus for the shared 13x11 multiplier arbiter.
// master = compute engines + result sink, slave = arbiter.
interface myproject_mul_share_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    localparam int unsigned A_W   = 13;
    localparam int unsigned B_W   = 11;
    localparam int unsigned P_W   = 24;
    localparam int unsigned CNT_W = 16;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic                res_valid;
    logic                res_ready;
    logic [P_W-1:0]      res_p;
    logic [ID_W-1:0]     res_id;
    logic                idle;
    logic [CNT_W-1:0]    op_count;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, res_id, idle, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, res_id, idle, op_count
    );
endinterface

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter time-sharing one unsigned 13x11 multiplier among NREQ
// requesters through a 2-stage pipeline; products return tagged with requester id.
module myproject_mul_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    myproject_mul_share_arb_if.slave  bus
);
    localparam int unsigned A_W   = 13;
    localparam int unsigned B_W   = 11;
    localparam int unsigned P_W   = 24;
    localparam int unsigned CNT_W = 16;

    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_valid;
    logic [A_W-1:0]   r_s1_a;
    logic [B_W-1:0]   r_s1_b;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_res_valid;
    logic [P_W-1:0]   r_res_p;
    logic [ID_W-1:0]  r_res_id;
    logic [CNT_W-1:0] r_op_count;

    logic             w_en;
    logic             w_found;
    logic             w_xfer;
    logic [ID_W-1:0]  w_grant;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [NREQ-1:0]  w_ready;
    logic [A_W-1:0]   w_a;
    logic [B_W-1:0]   w_b;
    int unsigned      w_idx;

    assign w_en = !r_res_valid || bus.res_ready;

    // First valid requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && bus.req_valid[ID_W'(w_idx)]) begin
                w_found = 1'b1;
                w_grant = ID_W'(w_idx);
            end
        end
    end

    // Grant is only offered while out of reset and the pipeline can advance.
    always_comb begin
        w_ready = '0;
        w_xfer  = w_found && w_en && ap_rst_n;
        if (w_xfer) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_a = bus.req_a[32'(w_grant)*A_W +: A_W];
        w_b = bus.req_b[32'(w_grant)*B_W +: B_W];
        if (32'(w_grant) == NREQ - 1) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_grant + ID_W'(1);
        end
    end

    // Arbitration pointer and accepted-request counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ptr      <= '0;
            r_op_count <= '0;
        end else if (w_xfer) begin
            r_ptr      <= w_ptr_nxt;
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    // Stage 1: operand capture; a bubble is inserted when nothing transfers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_a  <= w_a;
                r_s1_b  <= w_b;
                r_s1_id <= w_grant;
            end
        end
    end

    // Stage 2: full-width product; payload only moves with a real operation.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_res_valid <= 1'b0;
            r_res_p     <= '0;
            r_res_id    <= '0;
        end else if (w_en) begin
            r_res_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_p  <= P_W'(r_s1_a) * P_W'(r_s1_b);
                r_res_id <= r_s1_id;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_p     = r_res_p;
    assign bus.res_id    = r_res_id;
    assign bus.idle      = !r_s1_valid && !r_res_valid;
    assign bus.op_count  = r_op_count;
endmodule
